// File: rtl/iob_gpio_in.sv
// Debounced GPIO input block with edge capture, maskable level interrupt and CPU register access.
// Optional macro IOB_GPIO_IN_FALL_EN: EDGE captures falling as well as rising debounced edges.
module iob_gpio_in #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 2,
  parameter int N_IN        = 16,
  parameter int DEB_DEFAULT = 49999
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [N_IN-1:0]     gpio_in,
  output logic                irq
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] wmask;
  logic              wr_en;
  logic              rd_en;
  logic              sel_edge;
  logic              sel_mask;
  logic              sel_deb;

  logic [N_IN-1:0]   sync1_reg;
  logic [N_IN-1:0]   sync2_reg;
  logic [N_IN-1:0]   hist0_reg;
  logic [N_IN-1:0]   hist1_reg;
  logic [N_IN-1:0]   hist2_reg;
  logic [N_IN-1:0]   sw_state_reg;
  logic [N_IN-1:0]   sw_state_next;
  logic [N_IN-1:0]   sw_prev_reg;
  logic [N_IN-1:0]   edge_reg;
  logic [N_IN-1:0]   edge_next;
  logic [N_IN-1:0]   edge_set;
  logic [N_IN-1:0]   edge_clr;
  logic [N_IN-1:0]   irq_mask_reg;
  logic [N_IN-1:0]   irq_mask_next;
  logic [15:0]       presc_reg;
  logic [15:0]       deb_limit_reg;
  logic [15:0]       deb_limit_next;
  logic              tick;
  logic [DATA_W-1:0] rd_mux;

  // Byte enables expanded to a bit mask.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{wstrb[gi]}};
    end
  endgenerate

  assign wr_en    = valid && (|wstrb);
  assign rd_en    = valid && !(|wstrb);
  assign sel_edge = (address == ADDR_W'(1));
  assign sel_mask = (address == ADDR_W'(2));
  assign sel_deb  = (address == ADDR_W'(3));

  assign tick = (presc_reg == deb_limit_reg);

  // A bit's debounced state follows its history only once all three samples agree.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_deb
      logic agree;
      assign agree = (hist0_reg[gi] == hist1_reg[gi]) && (hist1_reg[gi] == hist2_reg[gi]);
      assign sw_state_next[gi] = agree ? hist0_reg[gi] : sw_state_reg[gi];
    end
  endgenerate

`ifdef IOB_GPIO_IN_FALL_EN
  assign edge_set = sw_state_reg ^ sw_prev_reg;
`else
  assign edge_set = sw_state_reg & ~sw_prev_reg;
`endif

  // A new edge wins over a simultaneous write-1-to-clear.
  assign edge_clr  = (wr_en && sel_edge) ? (wdata[N_IN-1:0] & wmask[N_IN-1:0]) : '0;
  assign edge_next = (edge_reg & ~edge_clr) | edge_set;

  always_comb begin
    irq_mask_next  = irq_mask_reg;
    deb_limit_next = deb_limit_reg;
    if (wr_en && sel_mask)
      irq_mask_next = (irq_mask_reg & ~wmask[N_IN-1:0]) | (wdata[N_IN-1:0] & wmask[N_IN-1:0]);
    if (wr_en && sel_deb)
      deb_limit_next = (deb_limit_reg & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_W'(0): rd_mux = DATA_W'(sw_state_reg);
      ADDR_W'(1): rd_mux = DATA_W'(edge_reg);
      ADDR_W'(2): rd_mux = DATA_W'(irq_mask_reg);
      ADDR_W'(3): rd_mux = DATA_W'(deb_limit_reg);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      hist0_reg     <= '0;
      hist1_reg     <= '0;
      hist2_reg     <= '0;
      sw_state_reg  <= '0;
      sw_prev_reg   <= '0;
      edge_reg      <= '0;
      irq_mask_reg  <= '0;
      presc_reg     <= '0;
      deb_limit_reg <= 16'(DEB_DEFAULT);
      rdata         <= '0;
      ready         <= 1'b0;
      irq           <= 1'b0;
    end else begin
      sync1_reg <= gpio_in;
      sync2_reg <= sync1_reg;
      if (tick) begin
        hist0_reg <= sync2_reg;
        hist1_reg <= hist0_reg;
        hist2_reg <= hist1_reg;
      end
      // A new limit restarts the prescaler so the first period is a full one.
      if ((wr_en && sel_deb) || tick)
        presc_reg <= '0;
      else
        presc_reg <= presc_reg + 16'd1;
      sw_state_reg  <= sw_state_next;
      sw_prev_reg   <= sw_state_reg;
      edge_reg      <= edge_next;
      irq_mask_reg  <= irq_mask_next;
      deb_limit_reg <= deb_limit_next;
      irq           <= |(edge_reg & irq_mask_reg);
      ready         <= valid;
      rdata         <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_iob_gpio_in.sv
// Scoreboard bench for iob_gpio_in: expected read data is queued as requests are issued
// and checked when ready returns; irq and reset behaviour are checked directly.
module tb_iob_gpio_in;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] gpio_in = '0;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          chk_q[$];
  logic [31:0] mon_exp;
  string       mon_tag;
  bit          mon_chk;

`ifdef IOB_GPIO_IN_FALL_EN
  localparam logic [31:0] EXP_FALL = 32'h8;
`else
  localparam logic [31:0] EXP_FALL = 32'h0;
`endif

  iob_gpio_in #(
    .DATA_W(32), .ADDR_W(2), .N_IN(16), .DEB_DEFAULT(49999)
  ) dut (
    .clk(clk), .arst_n(arst_n), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .gpio_in(gpio_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Completion monitor: every ready pops one queued request.
  always @(negedge clk) begin
    if (arst_n && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {31'b0, ready}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        mon_chk = chk_q.pop_front();
        if (mon_chk) check(mon_tag, rdata, mon_exp);
      end
    end
  end

  // Drives one request for one cycle; called at posedge+1, returns at posedge+1.
  task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] e, input bit c, input string t);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    exp_q.push_back(e); tag_q.push_back(t); chk_q.push_back(c);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    bus(a, 32'h0, 4'h0, e, 1'b1, t);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, d, s, 32'h0, 1'b0, "wr");
  endtask

  task automatic idle();
    valid = 1'b0; wstrb = '0; wdata = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 arst_n = 1'b0;
    cycles(3);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    arst_n = 1'b1;
    cycles(2);

    // Reset values, back-to-back reads
    rd(2'd0, 32'h0, "sw_rst");
    rd(2'd1, 32'h0, "edge_rst");
    rd(2'd2, 32'h0, "mask_rst");
    rd(2'd3, 32'd49999, "deb_rst");
    idle();

    // DEB_LIMIT=3, byte-strobed mask write
    wr(2'd3, 32'd3, 4'hF);
    wr(2'd2, 32'hFFFF_FFFF, 4'b0001);
    rd(2'd2, 32'h0000_00FF, "mask_bstrb");
    wr(2'd2, 32'h0, 4'hF);
    rd(2'd2, 32'h0, "mask_clr");
    idle();

    // Clean rising edge on bit 0
    gpio_in[0] = 1'b1;
    cycles(30);
    rd(2'd0, 32'h1, "sw0_rise");
    rd(2'd1, 32'h1, "edge0_rise");
    idle();
    check("irq_masked", {31'b0, irq}, 32'h0);

    // 5-cycle glitch on bit 5 must be filtered
    gpio_in[5] = 1'b1;
    cycles(5);
    gpio_in[5] = 1'b0;
    cycles(30);
    rd(2'd0, 32'h1, "glitch_sw");
    rd(2'd1, 32'h1, "glitch_edge");
    idle();

    // Interrupt on masked edge, cleared by W1C
    wr(2'd2, 32'h1, 4'hF);
    idle();
    cycles(2);
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h1, 4'hF);
    idle();
    check("irq_hold", {31'b0, irq}, 32'h1);
    cycles(1);
    check("irq_clr", {31'b0, irq}, 32'h0);
    rd(2'd1, 32'h0, "edge_w1c");
    idle();

    // DEB_LIMIT=0: W1C on bit 2 in the exact cycle its edge sets
    wr(2'd3, 32'h0, 4'hF);
    idle();
    cycles(2);
    gpio_in[2] = 1'b1;
    cycles(6);
    wr(2'd1, 32'h4, 4'hF);
    rd(2'd1, 32'h4, "edge_collide");
    wr(2'd1, 32'h4, 4'hF);
    rd(2'd1, 32'h0, "edge2_clr");
    idle();

    // Falling edge on bit 3
    gpio_in[3] = 1'b1;
    cycles(12);
    wr(2'd1, 32'h8, 4'hF);
    rd(2'd1, 32'h0, "edge3_rise_clr");
    idle();
    gpio_in[3] = 1'b0;
    cycles(12);
    rd(2'd1, EXP_FALL, "edge3_fall");
    rd(2'd0, 32'h5, "sw_after_fall");
    idle();
    check("irq_fall", {31'b0, irq}, 32'h0);

    // DEB_LIMIT byte strobes, then 7
    wr(2'd3, 32'hABCD_1234, 4'b0010);
    rd(2'd3, 32'h0000_1200, "deb_bstrb");
    wr(2'd3, 32'd7, 4'hF);
    rd(2'd3, 32'd7, "deb7");
    idle();
    cycles(2);

    // Reset in the middle of a read: no completion
    valid = 1'b1; address = 2'd3; wstrb = 4'h0;
    #2 arst_n = 1'b0;
    #1 check("abort_ready_now", {31'b0, ready}, 32'h0);
    cycles(3);
    check("abort_ready_rst", {31'b0, ready}, 32'h0);
    idle();
    arst_n = 1'b1;
    cycles(1);
    check("abort_ready_after", {31'b0, ready}, 32'h0);
    rd(2'd3, 32'd49999, "deb_after_rst");
    rd(2'd0, 32'h0, "sw_after_rst");
    rd(2'd1, 32'h0, "edge_after_rst");
    idle();

    // Pins high at reset release become rising edges once debounced
    wr(2'd3, 32'h0, 4'hF);
    idle();
    cycles(12);
    rd(2'd1, 32'h5, "edge_post_rst");
    rd(2'd0, 32'h5, "sw_post_rst");
    idle();
    cycles(3);

    check("pending", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
